// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS = 8;

    // Clock cycles per oversample tick.
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every DIV clocks.
module uart_baud_tick #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 2);

    logic [CW-1:0] cnt;

    // tick is registered one cycle early so it is high exactly while cnt == DIV-1
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
            tick <= (cnt == PRE_LAST);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with oversampled start/data/stop detection and a one-byte
// holding register using a valid/ack handshake.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      uart_rx,
    input  logic                      rd_ack,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      rx_irq
);

    localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam int unsigned BCW = $clog2(UART_DATA_BITS);
    localparam logic [SCW-1:0] HALF_LAST = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] FULL_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(UART_DATA_BITS - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_rx_core: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
        end
        if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
            $error("uart_rx_core: OVERSAMPLE must be even and at least 4");
        end
    endgenerate

    logic                      tick;
    logic                      rx_meta;
    logic                      rxs;
    uart_state_e               state;
    logic                      armed;
    logic [SCW-1:0]            scnt;
    logic [BCW-1:0]            bcnt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      deliver;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            armed     <= 1'b0;
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            deliver   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_irq    <= 1'b0;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
            deliver <= 1'b0;

            // Holding register handshake; an ack coinciding with delivery swaps in the new byte
            if (deliver) begin
                if (!rx_valid || rd_ack) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                    rx_irq   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rd_ack) begin
                rx_valid  <= 1'b0;
                rx_irq    <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (rxs) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            scnt  <= '0;
                            state <= START;
                        end
                    end
                    START: begin
                        if (scnt == HALF_LAST) begin
                            if (!rxs) begin
                                scnt  <= '0;
                                bcnt  <= '0;
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            scnt <= scnt + SCW'(1);
                        end
                    end
                    DATA: begin
                        if (scnt == FULL_LAST) begin
                            shreg <= {rxs, shreg[UART_DATA_BITS-1:1]};
                            scnt  <= '0;
                            bcnt  <= bcnt + BCW'(1);
                            if (bcnt == LAST_BIT) begin
                                state <= STOP;
                            end
                        end else begin
                            scnt <= scnt + SCW'(1);
                        end
                    end
                    STOP: begin
                        if (scnt == FULL_LAST) begin
                            scnt  <= '0;
                            state <= IDLE;
                            if (rxs) begin
                                deliver <= 1'b1;
                            end else begin
                                // Disarm so a held break cannot look like a new start bit
                                frame_err <= 1'b1;
                                armed     <= 1'b0;
                            end
                        end else begin
                            scnt <= scnt + SCW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver for the memory-mapped peripheral set in the MEM stage. It turns the serial uart_rx line into bytes.
- Frame format is 8N1, LSB first, idle-high line, sampled at OVERSAMPLE× the baud rate.
- It holds one received byte in a register with a valid/ack handshake to the peripheral read logic. It reports framing and overrun errors and drives a receive-interrupt level to the irq combiner.

Parameters:
- CLK_FREQ, 50_000_000: frequency of clk in Hz.
- BAUD, 9600: line rate in bits/s.
- OVERSAMPLE, 16: ticks per bit; must be even and ≥ 4.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE): derived, not overridable; synthesis error if < 2.

Ports:
- clk  in  1  CPU clock
- reset  in  1  synchronous, active-high
- uart_rx  in  1  asynchronous serial input, idle high
- rd_ack  in  1  one-cycle pulse: peripheral logic has consumed rx_data
- rx_data  out  8  last good received byte
- rx_valid  out  1  rx_data holds an unread byte
- frame_err  out  1  sticky; stop bit sampled low
- overrun  out  1  sticky; a good byte was dropped because rx_valid was still set
- rx_irq  out  1  equals rx_valid (level)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, rx_irq=0.
  - Synchronizer flops=1, FSM=IDLE, all counters=0.
- Input synchronizer: two flops on uart_rx. All decisions use the second-stage output (rxs). This adds 2 cycles of latency.
- Tick generator:
  - Free-running counter 0..DIV-1.
  - tick=1 for one cycle when the count is DIV-1; the count then wraps to 0.
  - Runs in every state.
- Per-tick sample counter: scnt, width clog2(OVERSAMPLE).
- Bit counter: bcnt, 0..7.
- FSM (all transitions on tick cycles only):
  - IDLE: armed flag is set when rxs==1 is seen. If armed and rxs==0: scnt←0, go to START.
  - START: scnt increments. When scnt==OVERSAMPLE/2-1, check rxs:
    - rxs==0: scnt←0, bcnt←0, go to DATA.
    - rxs==1: glitch; go to IDLE and stay armed.
  - DATA: scnt increments. When scnt==OVERSAMPLE-1: shift rxs into the MSB of the shift register (right shift, so LSB-first), scnt←0, bcnt increments. After bcnt reaches 7 and is sampled, go to STOP.
  - STOP: when scnt==OVERSAMPLE-1, sample rxs:
    - rxs==1: deliver the byte, go to IDLE, stay armed.
    - rxs==0: frame_err←1, discard the byte, go to IDLE with armed=0. A held break therefore does not retrigger.
- Delivery (the clock cycle after the stop-sample tick):
  - rx_valid==0: rx_data←shift register, rx_valid←1.
  - rx_valid==1 and rd_ack==0 in the same cycle: overrun←1, rx_data unchanged.
  - rx_valid==1 and rd_ack==1 in the same cycle: rx_data←new byte, rx_valid stays 1, no overrun.
- rd_ack (no delivery in the same cycle):
  - Clears rx_valid, frame_err and overrun on the next edge.
  - rd_ack while rx_valid==0 still clears the sticky flags and is otherwise ignored.
- Reset mid-frame: the frame is abandoned and all state returns to reset values. armed=0, so the line must be seen high before the next start bit.
- Latency: rx_valid rises (2 + 1) cycles plus at most DIV cycles of tick phase after the midpoint of the stop bit.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Constant UART_DATA_BITS=8.
  - Function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE; reused by the future transmitter.
- One sub-module, uart_baud_tick (parameter DIV; ports clk, reset, tick), shared with the transmitter. The FSM, shifter and handshake stay in uart_rx_core.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16 → DIV=10, 160 clk cycles per bit.
1. Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → rx_data=0xA5, rx_valid=1, rx_irq=1, frame_err=0; after a rd_ack pulse, rx_valid=0 on the next edge.
2. Drive a 40-cycle low glitch on an idle line → FSM returns to IDLE, rx_valid stays 0; a following 0x3C frame is received correctly.
3. Drive 0x55 with the stop bit held low, line held low for 5 bit times, then released and followed by 0x81 → frame_err=1, rx_valid=0, no spurious byte during the break; 0x81 is received afterwards.
4. Drive 0x11 then 0x22 with no rd_ack → rx_data=0x11, rx_valid=1, overrun=1; after rd_ack, all flags clear.
5. Pulse rd_ack in the exact delivery cycle of the second byte (0x11 then 0x22) → rx_data=0x22, rx_valid=1, overrun=0.
6. Assert reset during data bit 4 of 0xF0, release it, then send 0x0F → no byte delivered for 0xF0; 0x0F is received correctly.
